t_toggle_decoder: RTL and testbench

//   Receive-side counterpart of the T flip-flop. Watches a level signal q_in
//   and recovers the toggle stream: one t_out pulse per accepted level change.
//   A glitch filter rejects short excursions. A counter tallies the toggles.
//   A valid/ready event port hands each new level to a downstream consumer.
//   It sits after any toggle-encoded line, e.g. t_flip_flop.q.

---
 rtl/t_toggle_decoder.sv | 106 ++++++++++
 tb/tb_t_toggle_decoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/t_toggle_decoder.sv
// Recovers the toggle stream from a toggle-encoded level: glitch filter, toggle counter, valid/ready event port.
// Define TOGGLE_DEC_SAT_EN to make toggle_cnt saturate and raise the sticky ovf flag.
module t_toggle_decoder #(
  parameter int CNT_W    = 8,
  parameter int FILT_CYC = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             q_in,
  output logic             t_out,
  output logic             level,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_level,
  output logic             evt_lost,
  output logic             ovf,
  output logic             fsm_state
);

  localparam int FW = (FILT_CYC < 2) ? 1 : $clog2(FILT_CYC + 1);
  localparam logic [FW-1:0] FILT_LIM = FW'(FILT_CYC);

  typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_t;

  state_t        state;
  logic          q_s;
  logic [FW-1:0] filt_cnt;
  logic [FW-1:0] filt_nxt;
  logic          accept;

  assign filt_nxt  = filt_cnt + 1'b1;
  assign fsm_state = state;

  // A change is accepted once q_s has disagreed with level for FILT_CYC consecutive edges.
  always_comb begin
    accept = 1'b0;
    if (q_s != level) begin
      if (state == STABLE) accept = (FILT_CYC == 1);
      else                 accept = (filt_nxt == FILT_LIM);
    end
  end

  // Event handshake: an event transfers on any edge where evt_valid && evt_ready.
  // While evt_valid=1 and evt_ready=0 the event holds, except that a new accept
  // overwrites evt_level (latest level wins) and pulses evt_lost.
  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= STABLE;
      q_s        <= 1'b0;
      filt_cnt   <= '0;
      level      <= 1'b0;
      t_out      <= 1'b0;
      toggle_cnt <= '0;
      evt_valid  <= 1'b0;
      evt_level  <= 1'b0;
      evt_lost   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      q_s      <= q_in;
      t_out    <= 1'b0;
      evt_lost <= 1'b0;

      case (state)
        STABLE: begin
          if (q_s != level) begin
            filt_cnt <= FW'(1);
            if (!accept) state <= PENDING;
          end
        end
        PENDING: begin
          if (q_s == level) begin
            state    <= STABLE;
            filt_cnt <= '0;
          end else begin
            filt_cnt <= filt_nxt;
          end
        end
        default: state <= STABLE;
      endcase

      if (accept) begin
        state    <= STABLE;
        filt_cnt <= '0;
        level    <= ~level;
        t_out    <= 1'b1;
`ifdef TOGGLE_DEC_SAT_EN
        if (&toggle_cnt) ovf <= 1'b1;
        else             toggle_cnt <= toggle_cnt + 1'b1;
`else
        toggle_cnt <= toggle_cnt + 1'b1;
`endif
        if (evt_valid && !evt_ready) begin
          evt_level <= ~level;
          evt_lost  <= 1'b1;
        end else begin
          evt_valid <= 1'b1;
          evt_level <= ~level;
        end
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_t_toggle_decoder.sv
// Directed bench for t_toggle_decoder: default-width instance plus a CNT_W=4 instance for wrap/saturation.
module tb_t_toggle_decoder;

  localparam int W = 1;

  // clock / reset
  logic clk = 1'b0;
  logic clear, q_in, evt_ready;
  always #5 clk = ~clk;

  logic       t_out, level, evt_valid, evt_level, evt_lost, ovf, fsm_state;
  logic [7:0] toggle_cnt;
  logic       w4_t_out, w4_level, w4_evt_valid, w4_evt_level, w4_evt_lost, w4_ovf, w4_fsm_state;
  logic [3:0] w4_toggle_cnt;

  t_toggle_decoder dut (
    .clk(clk), .clear(clear), .q_in(q_in), .t_out(t_out), .level(level),
    .toggle_cnt(toggle_cnt), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_level(evt_level), .evt_lost(evt_lost), .ovf(ovf), .fsm_state(fsm_state)
  );

  t_toggle_decoder #(.CNT_W(4), .FILT_CYC(2)) dut_w4 (
    .clk(clk), .clear(clear), .q_in(q_in), .t_out(w4_t_out), .level(w4_level),
    .toggle_cnt(w4_toggle_cnt), .evt_valid(w4_evt_valid), .evt_ready(evt_ready),
    .evt_level(w4_evt_level), .evt_lost(w4_evt_lost), .ovf(w4_ovf), .fsm_state(w4_fsm_state)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] hs_q[$];
  int hs_rd = 0;
  int pulse_cnt = 0;
  int lost_cnt = 0;
  int total = 0;
  int bad = 0;

  // observe the main instance between edges
  always @(negedge clk) begin
    if (t_out === 1'b1) pulse_cnt = pulse_cnt + 1;
    if (evt_lost === 1'b1) lost_cnt = lost_cnt + 1;
    if (evt_valid === 1'b1 && evt_ready === 1'b1) hs_q.push_back(evt_level);
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    clear = 1'b1; q_in = 1'b0; evt_ready = 1'b0;
    step(2);
    clear = 1'b0;
    step(2);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_drain(input string tag);
    logic [W-1:0] e;
    chk({tag, "_hs_count"}, hs_q.size() - hs_rd, exp_q.size());
    while (exp_q.size() > 0 && hs_rd < hs_q.size()) begin
      e = exp_q.pop_front();
      chk({tag, "_hs_level"}, hs_q[hs_rd], e);
      hs_rd++;
    end
    exp_q.delete();
    hs_rd = hs_q.size();
  endtask

  int p0, l0;
  logic exp_lvl;

  initial begin
    // 1: reset with q_in high, then release
    clear = 1'b1; q_in = 1'b1; evt_ready = 1'b0;
    step(3);
    chk("rst_level", level, 0);
    chk("rst_t_out", t_out, 0);
    chk("rst_cnt", toggle_cnt, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_level", evt_level, 0);
    chk("rst_evt_lost", evt_lost, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_state", fsm_state, 0);
    p0 = pulse_cnt;
    clear = 1'b0;
    step(1);
    chk("t1_tout_e1", t_out, 0);
    step(1);
    chk("t1_tout_e2", t_out, 0);
    chk("t1_pending", fsm_state, 1);
    step(1);
    chk("t1_tout_e3", t_out, 1);
    chk("t1_level", level, 1);
    chk("t1_cnt", toggle_cnt, 1);
    chk("t1_evt_valid", evt_valid, 1);
    chk("t1_evt_level", evt_level, 1);
    step(1);
    chk("t1_tout_drop", t_out, 0);
    chk("t1_pulses", pulse_cnt - p0, 1);

    // 2: single-cycle glitch is rejected
    do_reset();
    p0 = pulse_cnt;
    q_in = 1'b1;
    step(1);
    q_in = 1'b0;
    step(1);
    chk("t2_pending", fsm_state, 1);
    step(4);
    chk("t2_state", fsm_state, 0);
    chk("t2_pulses", pulse_cnt - p0, 0);
    chk("t2_cnt", toggle_cnt, 0);
    chk("t2_level", level, 0);
    chk("t2_evt_valid", evt_valid, 0);

    // 3: four clean toggles with consumer always ready
    do_reset();
    p0 = pulse_cnt; l0 = lost_cnt;
    evt_ready = 1'b1;
    exp_lvl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q_in = ~q_in;
      exp_lvl = ~exp_lvl;
      exp_q.push_back(exp_lvl);
      step(10);
    end
    chk("t3_pulses", pulse_cnt - p0, 4);
    chk("t3_cnt", toggle_cnt, 4);
    chk("t3_level", level, 0);
    chk("t3_lost", lost_cnt - l0, 0);
    chk("t3_evt_valid", evt_valid, 0);
    sb_drain("t3");

    // 4: consumer stalled, second toggle overwrites the first event
    do_reset();
    l0 = lost_cnt;
    q_in = 1'b1;
    step(10);
    q_in = 1'b0;
    step(10);
    chk("t4_lost", lost_cnt - l0, 1);
    chk("t4_evt_level", evt_level, 0);
    chk("t4_evt_valid", evt_valid, 1);
    chk("t4_cnt", toggle_cnt, 2);
    step(3);
    chk("t4_hold_valid", evt_valid, 1);
    chk("t4_hold_level", evt_level, 0);
    evt_ready = 1'b1;
    exp_q.push_back(1'b0);
    step(1);
    evt_ready = 1'b0;
    chk("t4_consumed", evt_valid, 0);
    step(3);
    sb_drain("t4");

    // 4b: handshake and accept on the same edge, no loss flagged
    q_in = 1'b1;
    step(10);
    chk("t4b_cnt3", toggle_cnt, 3);
    chk("t4b_evt_level1", evt_level, 1);
    l0 = lost_cnt;
    q_in = 1'b0;
    step(2);
    evt_ready = 1'b1;
    exp_q.push_back(1'b1);
    step(1);
    evt_ready = 1'b0;
    chk("t4b_accept_edge", t_out, 1);
    chk("t4b_evt_valid", evt_valid, 1);
    chk("t4b_evt_level", evt_level, 0);
    step(1);
    chk("t4b_lost", lost_cnt - l0, 0);
    chk("t4b_cnt4", toggle_cnt, 4);
    sb_drain("t4b");

    // 5: narrow counter wrap / saturation over 17 toggles
    do_reset();
    evt_ready = 1'b1;
    exp_lvl = 1'b0;
    for (int i = 0; i < 15; i++) begin
      q_in = ~q_in;
      exp_lvl = ~exp_lvl;
      exp_q.push_back(exp_lvl);
      step(4);
    end
    chk("t5_w4_cnt15", w4_toggle_cnt, 15);
    chk("t5_w4_ovf15", w4_ovf, 0);
    q_in = ~q_in; exp_lvl = ~exp_lvl; exp_q.push_back(exp_lvl);
    step(4);
`ifdef TOGGLE_DEC_SAT_EN
    chk("t5_w4_cnt16", w4_toggle_cnt, 15);
    chk("t5_w4_ovf16", w4_ovf, 1);
`else
    chk("t5_w4_cnt16", w4_toggle_cnt, 0);
    chk("t5_w4_ovf16", w4_ovf, 0);
`endif
    q_in = ~q_in; exp_lvl = ~exp_lvl; exp_q.push_back(exp_lvl);
    step(5);
`ifdef TOGGLE_DEC_SAT_EN
    chk("t5_w4_cnt17", w4_toggle_cnt, 15);
    chk("t5_w4_ovf17", w4_ovf, 1);
`else
    chk("t5_w4_cnt17", w4_toggle_cnt, 1);
    chk("t5_w4_ovf17", w4_ovf, 0);
`endif
    chk("t5_w4_level", w4_level, 1);
    chk("t5_cnt17", toggle_cnt, 17);
    chk("t5_ovf", ovf, 0);
    sb_drain("t5");

    // 6: clear while a candidate is pending
    do_reset();
    p0 = pulse_cnt;
    q_in = 1'b1;
    step(2);
    chk("t6_pending", fsm_state, 1);
    clear = 1'b1;
    q_in = 1'b0;
    step(1);
    chk("t6_state", fsm_state, 0);
    chk("t6_t_out", t_out, 0);
    chk("t6_level", level, 0);
    chk("t6_cnt", toggle_cnt, 0);
    chk("t6_evt_lost", evt_lost, 0);
    step(1);
    clear = 1'b0;
    step(3);
    chk("t6_no_pulse", pulse_cnt - p0, 0);
    q_in = 1'b1;
    step(4);
    chk("t6_after_cnt", toggle_cnt, 1);
    chk("t6_after_level", level, 1);
    chk("t6_after_evt", evt_valid, 1);
    chk("t6_after_pulse", pulse_cnt - p0, 1);
    sb_drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
